fibre_a_responder: RTL and testbench
====================================

FIBRE_A_RESPONDER -- requirements
Module: fibre_a_responder

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter TIMESTEPS, default 4, spike bits per fibre entry.
REQ-003 Parameter ADDR_WIDTH, default 8, fibre address width; each bank depth DEPTH = 2^ADDR_WIDTH.
REQ-004 Parameter READ_LATENCY, default 2, legal range 1..4, cycles from read request to response.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 wr_valid  input  1  load beat valid.
REQ-008 wr_ready  output  1  load beat accepted when both high.
REQ-009 wr_data  input  TIMESTEPS  spike vector for next shadow entry.
REQ-010 wr_last  input  1  final beat of fibre.
REQ-011 fibre_a_addr  input  ADDR_WIDTH  read address from TPPE.
REQ-012 fibre_a_read_en  input  1  read request, one per cycle max, no backpressure.
REQ-013 fibre_a_data  output  TIMESTEPS  read response data.
REQ-014 fibre_a_valid  output  1  response strobe, single-cycle per request.
REQ-015 fibre_len  output  ADDR_WIDTH+1  entry count of active bank.
REQ-016 bank_ready  output  1  active bank holds a loaded fibre.
REQ-017 addr_error  output  1  pulses with fibre_a_valid for an invalid read.

Function
REQ-018 Two banks of DEPTH x TIMESTEPS; act_sel selects the active (read) bank, the other is shadow (write).
REQ-019 Load FSM states IDLE, FILL, SWAP; wr_ready = 1 in IDLE and FILL, 0 in SWAP and during reset.
REQ-020 IDLE: accepted beat writes shadow[0], wptr <= 1; -> SWAP if wr_last, else -> FILL.
REQ-021 FILL: accepted beat writes shadow[wptr], wptr++; -> SWAP on wr_last or when wptr = DEPTH-1 (beat at last address forced final).
REQ-022 SWAP: one cycle; act_sel toggles, fibre_len <= count of beats loaded (1..DEPTH), bank_ready <= 1; -> IDLE, wptr <= 0.
REQ-023 Read accepted every cycle fibre_a_read_en = 1 regardless of FSM state; never stalled or dropped.
REQ-024 Read data captured from active bank in the request cycle, then delayed through a READ_LATENCY-stage valid/data pipeline.
REQ-025 Request at edge t SHALL yield fibre_a_valid = 1 exactly at edge t+READ_LATENCY; back-to-back requests yield back-to-back responses in order.
REQ-026 Read issued in the SWAP cycle SHALL return old-bank data; first read after SWAP returns new-bank data.
REQ-027 Invalid read (bank_ready = 0 or fibre_a_addr >= fibre_len): fibre_a_data = 0, fibre_a_valid = 1, addr_error = 1 same cycle.
REQ-028 fibre_a_data SHALL be 0 whenever fibre_a_valid = 0.
REQ-029 Writes never touch the active bank; read/write same index same cycle has no interaction.
REQ-030 wr_valid with wr_ready = 0 SHALL be ignored (no write, no pointer change).

Reset
REQ-031 On rst low: FSM IDLE, wptr 0, act_sel 0, fibre_len 0, bank_ready 0, pipeline cleared, fibre_a_valid 0, fibre_a_data 0, addr_error 0, wr_ready 0.
REQ-032 Reset mid-load or mid-read SHALL discard partial load and all in-flight responses; bank contents need not be cleared.
REQ-033 wr_ready SHALL rise in the first cycle after rst deasserts.

Verification
REQ-034 Load 4 beats 0x1,0x2,0x4,0x8 with wr_last on beat 4 -> one SWAP cycle, fibre_len = 4, bank_ready = 1; reads addr 0..3 -> data 0x1,0x2,0x4,0x8, each 2 cycles after request.
REQ-035 Read addr 4 with fibre_len = 4 -> fibre_a_valid = 1, data 0x0, addr_error = 1; read before any load -> same.
REQ-036 Continuous reads of addr 0 while loading second fibre 0xF (1 beat) -> responses 0x1 up to and including the SWAP-cycle request, 0xF thereafter, no gap in fibre_a_valid.
REQ-037 Load 256 beats with wr_last never asserted -> forced SWAP after beat 256, fibre_len = 256, read addr 255 returns beat 256 data.
REQ-038 Assert rst low with 2 reads in flight and 3 beats into a load -> fibre_a_valid stays 0, bank_ready 0, fibre_len 0; new 1-beat load after release succeeds.
REQ-039 wr_valid toggling at random with READ_LATENCY = 1 and 4 -> scoreboard matches every response to its request, latency exact.

Source files
------------

// File: rtl/fibre_a_responder.sv
// rtl/fibre_a_responder.sv - double-banked fibre store with fixed-latency read port
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   wr_valid/wr_ready   load beat handshake into the shadow bank
//   wr_data, wr_last    spike vector for the next shadow entry, final beat flag
//   fibre_a_addr        read address, sampled when fibre_a_read_en is high
//   fibre_a_read_en     read request, at most one per cycle, never stalled
//   fibre_a_data        response data (zero unless a valid in-range response)
//   fibre_a_valid       single-cycle response strobe, READ_LATENCY after request
//   fibre_len           number of entries in the active bank
//   bank_ready          active bank holds a loaded fibre
//   addr_error          marks a response to an out-of-range or premature read

module fibre_a_responder #(
    parameter int TIMESTEPS    = 4,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [TIMESTEPS-1:0]  wr_data,
    input  logic                  wr_last,
    input  logic [ADDR_WIDTH-1:0] fibre_a_addr,
    input  logic                  fibre_a_read_en,
    output logic [TIMESTEPS-1:0]  fibre_a_data,
    output logic                  fibre_a_valid,
    output logic [ADDR_WIDTH:0]   fibre_len,
    output logic                  bank_ready,
    output logic                  addr_error
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] LAST_IDX = {1'b0, {ADDR_WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SWAP = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH:0]   wptr;
    logic                  act_sel;
    logic                  wr_fire;

    // Both banks live in one array; the top address bit selects the bank.
    logic [TIMESTEPS-1:0]  mem [2*DEPTH];

    assign wr_fire = wr_valid & wr_ready;

    // Load FSM. wr_ready is registered so it stays low throughout reset and
    // rises on the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wptr       <= '0;
            act_sel    <= 1'b0;
            fibre_len  <= '0;
            bank_ready <= 1'b0;
            wr_ready   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wr_ready <= 1'b1;
                    if (wr_fire) begin
                        wptr <= PTR_ONE;
                        if (wr_last) begin
                            state    <= SWAP;
                            wr_ready <= 1'b0;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (wr_fire) begin
                        wptr <= wptr + PTR_ONE;
                        // A beat landing on the last address closes the fibre.
                        if (wr_last || (wptr == LAST_IDX)) begin
                            state    <= SWAP;
                            wr_ready <= 1'b0;
                        end
                    end
                end
                SWAP: begin
                    act_sel    <= ~act_sel;
                    fibre_len  <= wptr;
                    bank_ready <= 1'b1;
                    wptr       <= '0;
                    wr_ready   <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    wr_ready <= 1'b0;
                end
            endcase
        end
    end

    // Writes only ever target the shadow bank.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{~act_sel, wptr[ADDR_WIDTH-1:0]}] <= wr_data;
        end
    end

    logic                 rd_ok;
    logic [TIMESTEPS-1:0] rd_word;

    // act_sel and fibre_len only change at the end of SWAP, so a read in the
    // SWAP cycle still sees the old bank.
    assign rd_ok   = bank_ready && ({1'b0, fibre_a_addr} < fibre_len);
    assign rd_word = mem[{act_sel, fibre_a_addr}];

    logic [READ_LATENCY-1:0] vld_pipe;
    logic [READ_LATENCY-1:0] err_pipe;
    logic [TIMESTEPS-1:0]    dat_pipe [READ_LATENCY];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            err_pipe <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0] <= fibre_a_read_en;
            err_pipe[0] <= fibre_a_read_en & ~rd_ok;
            dat_pipe[0] <= (fibre_a_read_en && rd_ok) ? rd_word : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                err_pipe[i] <= err_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign fibre_a_valid = vld_pipe[READ_LATENCY-1];
    assign addr_error    = err_pipe[READ_LATENCY-1];
    assign fibre_a_data  = dat_pipe[READ_LATENCY-1];

endmodule

// File: tb/tb_fibre_a_responder.sv
// tb/tb_fibre_a_responder.sv - scoreboard bench for fibre_a_responder at read latencies 1, 2 and 4

module tb_fibre_a_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_last = 1'b0;
    logic [3:0] wr_data = '0;
    logic       read_en = 1'b0;
    logic [7:0] addr = '0;

    logic       rdy  [3];
    logic       vld  [3];
    logic       brdy [3];
    logic       aerr [3];
    logic [3:0] rdat [3];
    logic [8:0] flen [3];

    always #5 clk = ~clk;

    fibre_a_responder #(.TIMESTEPS(4), .ADDR_WIDTH(8), .READ_LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(rdy[0]), .wr_data(wr_data),
        .wr_last(wr_last), .fibre_a_addr(addr), .fibre_a_read_en(read_en),
        .fibre_a_data(rdat[0]), .fibre_a_valid(vld[0]), .fibre_len(flen[0]),
        .bank_ready(brdy[0]), .addr_error(aerr[0]));

    fibre_a_responder #(.TIMESTEPS(4), .ADDR_WIDTH(8), .READ_LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(rdy[1]), .wr_data(wr_data),
        .wr_last(wr_last), .fibre_a_addr(addr), .fibre_a_read_en(read_en),
        .fibre_a_data(rdat[1]), .fibre_a_valid(vld[1]), .fibre_len(flen[1]),
        .bank_ready(brdy[1]), .addr_error(aerr[1]));

    fibre_a_responder #(.TIMESTEPS(4), .ADDR_WIDTH(8), .READ_LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(rdy[2]), .wr_data(wr_data),
        .wr_last(wr_last), .fibre_a_addr(addr), .fibre_a_read_en(read_en),
        .fibre_a_data(rdat[2]), .fibre_a_valid(vld[2]), .fibre_len(flen[2]),
        .bank_ready(brdy[2]), .addr_error(aerr[2]));

    typedef struct {
        int         due;
        logic [3:0] data;
        logic       err;
    } exp_t;

    typedef struct {
        logic [7:0] addr;
        logic [3:0] data;
        logic       err;
    } vec_t;

    exp_t sbq [3][$];
    int   lat [3];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   cyc       = 0;

    logic [3:0] m_act [256];
    logic [3:0] m_shd [256];
    int         m_len, m_cnt;
    bit         m_ready, m_swap, m_rdy_ok;

    bit         ovr_en   = 1'b0;
    logic [3:0] ovr_data = '0;
    logic       ovr_err  = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, want, cyc);
    endtask

    task automatic reset_model();
        m_len = 0; m_cnt = 0; m_ready = 1'b0; m_swap = 1'b0; m_rdy_ok = 1'b0;
        for (int k = 0; k < 3; k++) sbq[k].delete();
    endtask

    // One clock cycle: queue the expected response, clock, update the model,
    // then check every instance on the falling edge.
    task automatic step();
        exp_t e;
        bit   acc, swp, exp_rdy;
        if (read_en) begin
            if (ovr_en) begin
                e.data = ovr_data; e.err = ovr_err;
            end else if (!m_ready || int'(addr) >= m_len) begin
                e.data = 4'h0; e.err = 1'b1;
            end else begin
                e.data = m_act[addr]; e.err = 1'b0;
            end
            for (int k = 0; k < 3; k++) begin
                e.due = cyc + lat[k];
                sbq[k].push_back(e);
            end
        end
        acc = wr_valid && m_rdy_ok && !m_swap && rst;
        swp = m_swap;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_rdy_ok = 1'b1;
            if (swp) begin
                m_act = m_shd; m_len = m_cnt; m_ready = 1'b1; m_cnt = 0; m_swap = 1'b0;
            end
            if (acc) begin
                m_shd[m_cnt] = wr_data;
                m_cnt++;
                if (wr_last || m_cnt == 256) m_swap = 1'b1;
            end
        end
        @(negedge clk);
        exp_rdy = m_rdy_ok && !m_swap && rst;
        for (int k = 0; k < 3; k++) begin
            if (vld[k]) begin
                if (sbq[k].size() == 0) begin
                    chk($sformatf("L%0d spurious valid", lat[k]), vld[k], 0);
                end else begin
                    e = sbq[k].pop_front();
                    chk($sformatf("L%0d latency", lat[k]), cyc, e.due);
                    chk($sformatf("L%0d data", lat[k]), rdat[k], e.data);
                    chk($sformatf("L%0d addr_error", lat[k]), aerr[k], e.err);
                end
            end else begin
                chk($sformatf("L%0d idle data/err", lat[k]), {rdat[k], aerr[k]}, 0);
                if (sbq[k].size() > 0 && sbq[k][0].due <= cyc) begin
                    chk($sformatf("L%0d missing response", lat[k]), vld[k], 1);
                    void'(sbq[k].pop_front());
                end
            end
            chk($sformatf("L%0d wr_ready", lat[k]), rdy[k], exp_rdy);
            chk($sformatf("L%0d fibre_len", lat[k]), flen[k], m_len);
            chk($sformatf("L%0d bank_ready", lat[k]), brdy[k], m_ready);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        vec_t tbl [7];
        tbl[0] = '{8'd0,   4'h1, 1'b0};
        tbl[1] = '{8'd1,   4'h2, 1'b0};
        tbl[2] = '{8'd2,   4'h4, 1'b0};
        tbl[3] = '{8'd3,   4'h8, 1'b0};
        tbl[4] = '{8'd4,   4'h0, 1'b1};
        tbl[5] = '{8'd255, 4'h0, 1'b1};
        tbl[6] = '{8'd3,   4'h8, 1'b0};
        lat[0] = 1; lat[1] = 2; lat[2] = 4;
        reset_model();

        // Reset state
        idle(2);
        for (int k = 0; k < 3; k++) begin
            chk("reset valid", vld[k], 0);
            chk("reset wr_ready", rdy[k], 0);
            chk("reset fibre_len", flen[k], 0);
            chk("reset bank_ready", brdy[k], 0);
        end
        rst = 1'b1;
        idle(1);

        // Read before any load is an error response
        read_en = 1'b1; addr = 8'd0; ovr_en = 1'b1; ovr_data = 4'h0; ovr_err = 1'b1;
        step();
        read_en = 1'b0; ovr_en = 1'b0;
        idle(5);

        // Four-beat fibre, then one SWAP cycle
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_data = 4'(1 << i); wr_last = (i == 3);
            step();
        end
        wr_valid = 1'b0; wr_last = 1'b0;
        chk("SWAP cycle wr_ready low", rdy[1], 0);
        step();
        chk("fibre_len after load", flen[1], 4);
        chk("bank_ready after load", brdy[1], 1);

        // Table-driven reads, back to back
        for (int i = 0; i < 7; i++) begin
            read_en = 1'b1; addr = tbl[i].addr;
            ovr_en = 1'b1; ovr_data = tbl[i].data; ovr_err = tbl[i].err;
            step();
        end
        read_en = 1'b0; ovr_en = 1'b0;
        idle(5);

        // Continuous reads of addr 0 across a 1-beat reload
        read_en = 1'b1; addr = 8'd0;
        idle(2);
        wr_valid = 1'b1; wr_data = 4'hF; wr_last = 1'b1;
        step();
        wr_valid = 1'b0; wr_last = 1'b0;
        idle(5);
        read_en = 1'b0;
        idle(5);

        // 256 beats without wr_last forces the swap
        for (int i = 0; i < 256; i++) begin
            wr_valid = 1'b1; wr_data = 4'((i * 7 + 3) & 15); wr_last = 1'b0;
            step();
        end
        wr_valid = 1'b0;
        idle(2);
        chk("forced fibre_len", flen[1], 256);
        read_en = 1'b1; addr = 8'd255; ovr_en = 1'b1; ovr_data = 4'((255 * 7 + 3) & 15); ovr_err = 1'b0;
        step();
        ovr_en = 1'b0; addr = 8'd0;
        step();
        read_en = 1'b0;
        idle(5);

        // Reset with a partial load and reads in flight
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_data = 4'h5; wr_last = 1'b0;
            read_en = (i > 0); addr = 8'd1;
            step();
        end
        rst = 1'b0; wr_valid = 1'b0; read_en = 1'b0;
        reset_model();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("mid-reset valid", vld[k], 0);
            chk("mid-reset bank_ready", brdy[k], 0);
            chk("mid-reset fibre_len", flen[k], 0);
        end
        idle(3);
        rst = 1'b1;
        idle(1);
        wr_valid = 1'b1; wr_data = 4'h9; wr_last = 1'b1;
        step();
        wr_valid = 1'b0; wr_last = 1'b0;
        step();
        read_en = 1'b1; addr = 8'd0; ovr_en = 1'b1; ovr_data = 4'h9; ovr_err = 1'b0;
        step();
        addr = 8'd1; ovr_data = 4'h0; ovr_err = 1'b1;
        step();
        read_en = 1'b0; ovr_en = 1'b0;
        idle(5);

        // Random loads and reads
        for (int i = 0; i < 800; i++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = 4'($urandom_range(0, 15));
            wr_last  = ($urandom_range(0, 4) == 0);
            read_en  = 1'($urandom_range(0, 1));
            addr     = 8'($urandom_range(0, 7));
            step();
        end
        wr_valid = 1'b0; wr_last = 1'b0; read_en = 1'b0;
        idle(6);
        for (int k = 0; k < 3; k++) chk("scoreboard drained", sbq[k].size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
